// File: rtl/index_brush_writer_if.sv
// index_brush_writer_if: paint-command handshake and frame-RAM write port of the index brush writer.
interface index_brush_writer_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8,
    parameter int R_W    = 4
);
    logic              iCMD_VALID;
    logic              oCMD_READY;
    logic              iCLEAR;
    logic [9:0]        iX;
    logic [8:0]        iY;
    logic [R_W-1:0]    iRADIUS;
    logic [DATA_W-1:0] iINDEX;
    logic [ADDR_W-1:0] oADDR;
    logic [DATA_W-1:0] oDATA;
    logic              oWREN;
    logic              oBUSY;
    logic              oDONE;
    modport master (
        output iCMD_VALID, iCLEAR, iX, iY, iRADIUS, iINDEX,
        input  oCMD_READY, oADDR, oDATA, oWREN, oBUSY, oDONE
    );
    modport slave (
        input  iCMD_VALID, iCLEAR, iX, iY, iRADIUS, iINDEX,
        output oCMD_READY, oADDR, oDATA, oWREN, oBUSY, oDONE
    );
endinterface

// File: rtl/index_brush_writer.sv
// index_brush_writer: paints clipped square brush stamps or full-screen clears into the colour-index frame RAM.
// Define ROUND_BRUSH_EN to mask brush stamps to a disc of radius R.
module index_brush_writer #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8,
    parameter int R_W    = 4
) (
    input logic                iVGA_CLK,
    input logic                iRST,
    index_brush_writer_if.slave bus
);
    localparam logic [9:0]        XMAX = 10'(H_RES - 1);
    localparam logic [8:0]        YMAX = 9'(V_RES - 1);
    localparam logic [ADDR_W-1:0] ROW  = ADDR_W'(H_RES);

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;
    state_t state;

    logic              clr;
    logic [9:0]        xc, x0, x1, cx, bx0, bx1;
    logic [8:0]        yc, y1, cy, by0, by1;
    logic [R_W-1:0]    r;
    logic [DATA_W-1:0] idx;
    logic [ADDR_W-1:0] row_base;
    logic signed [11:0] xl, xh, yl, yh;
    logic              empty, last_x, last, paint;

    always_comb begin
        xl     = $signed(12'(xc)) - $signed(12'(r));
        xh     = $signed(12'(xc)) + $signed(12'(r));
        yl     = $signed(12'(yc)) - $signed(12'(r));
        yh     = $signed(12'(yc)) + $signed(12'(r));
        bx0    = (clr || xl[11]) ? '0 : xl[9:0];
        bx1    = (clr || xh > $signed(12'(XMAX))) ? XMAX : xh[9:0];
        by0    = (clr || yl[11]) ? '0 : yl[8:0];
        by1    = (clr || yh > $signed(12'(YMAX))) ? YMAX : yh[8:0];
        empty  = !clr && (xc > XMAX || yc > YMAX);
        last_x = cx == x1;
        last   = last_x && cy == y1;
    end

`ifdef ROUND_BRUSH_EN
    logic [9:0]     adx;
    logic [8:0]     ady;
    logic [2*R_W:0] ax, ay;
    // Visited positions never lie further than R from the centre, so |dx|,|dy| fit in R_W bits.
    always_comb begin
        adx   = cx >= xc ? cx - xc : xc - cx;
        ady   = cy >= yc ? cy - yc : yc - cy;
        ax    = (2*R_W+1)'(adx[R_W-1:0]);
        ay    = (2*R_W+1)'(ady[R_W-1:0]);
        paint = clr || (ax * ax + ay * ay <= (2*R_W+1)'(r) * (2*R_W+1)'(r));
    end
`else
    assign paint = 1'b1;
`endif

    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            state          <= IDLE;
            bus.oADDR      <= '0;
            bus.oDATA      <= '0;
            bus.oWREN      <= 1'b0;
            bus.oDONE      <= 1'b0;
            bus.oBUSY      <= 1'b0;
            bus.oCMD_READY <= 1'b0;
            clr            <= 1'b0;
            xc             <= '0;
            yc             <= '0;
            r              <= '0;
            idx            <= '0;
            x0             <= '0;
            x1             <= '0;
            y1             <= '0;
            cx             <= '0;
            cy             <= '0;
            row_base       <= '0;
        end else begin
            bus.oWREN <= 1'b0;
            bus.oDONE <= 1'b0;
            case (state)
                IDLE: begin
                    bus.oCMD_READY <= !(bus.iCMD_VALID && bus.oCMD_READY);
                    if (bus.iCMD_VALID && bus.oCMD_READY) begin
                        clr       <= bus.iCLEAR;
                        xc        <= bus.iX;
                        yc        <= bus.iY;
                        r         <= bus.iRADIUS;
                        idx       <= bus.iINDEX;
                        bus.oBUSY <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    x0       <= bx0;
                    x1       <= bx1;
                    y1       <= by1;
                    cx       <= bx0;
                    cy       <= by0;
                    row_base <= ADDR_W'(by0) * ROW;
                    state    <= empty ? DONE : DRAW;
                end
                DRAW: begin
                    bus.oADDR <= row_base + ADDR_W'(cx);
                    bus.oDATA <= idx;
                    bus.oWREN <= paint;
                    cx        <= last_x ? x0 : cx + 10'd1;
                    cy        <= last_x ? cy + 9'd1 : cy;
                    row_base  <= last_x ? row_base + ROW : row_base;
                    state     <= last ? DONE : DRAW;
                end
                default: begin
                    bus.oDONE      <= 1'b1;
                    bus.oBUSY      <= 1'b0;
                    bus.oCMD_READY <= 1'b1;
                    state          <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_index_brush_writer.sv
// tb_index_brush_writer: scoreboard bench for index_brush_writer (full size) plus a small-screen instance for clear.
module tb_index_brush_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    index_brush_writer_if b ();
    index_brush_writer_if bs ();

    index_brush_writer u_dut (.iVGA_CLK(clk), .iRST(rst), .bus(b));
    index_brush_writer #(.H_RES(32), .V_RES(24)) u_small (.iVGA_CLK(clk), .iRST(rst), .bus(bs));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0, hs_last = 0, hs_cnt = 0;
    int wr_cnt = 0, first_wr = -1, done_cyc = -1;
    int s_next = 0;
    bit s_done = 0;
    int q_addr[$];
    int q_data[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (b.iCMD_VALID && b.oCMD_READY) begin
            hs_last = cyc;
            hs_cnt++;
        end
    end

    always @(negedge clk) begin
        if (b.oWREN) begin
            wr_cnt++;
            if (first_wr < 0) first_wr = cyc;
            if (q_addr.size() != 0) begin
                chk("addr", 32'(b.oADDR), q_addr.pop_front());
                chk("data", 32'(b.oDATA), q_data.pop_front());
            end
        end
        if (b.oDONE) done_cyc = cyc;
        if (bs.oWREN) begin
            chk("s_addr", 32'(bs.oADDR), s_next);
            chk("s_data", 32'(bs.oDATA), 32'h5C);
            s_next++;
        end
        if (bs.oDONE) s_done = 1;
    end

    // Reference: clipped square in raster order; p = positions visited, f = position of first write.
    task automatic model(input logic clr, input int x, y, r, idx, output int p, f, nw);
        int x0, x1, y0, y1;
        bit ok;
        p = 0; f = -1; nw = 0;
        if (!clr && (x >= 640 || y >= 480)) return;
        x0 = clr ? 0 : (x - r < 0 ? 0 : x - r);
        x1 = clr ? 639 : (x + r > 639 ? 639 : x + r);
        y0 = clr ? 0 : (y - r < 0 ? 0 : y - r);
        y1 = clr ? 479 : (y + r > 479 ? 479 : y + r);
        for (int yy = y0; yy <= y1; yy++)
            for (int xx = x0; xx <= x1; xx++) begin
                ok = 1;
`ifdef ROUND_BRUSH_EN
                if (!clr && (xx - x) * (xx - x) + (yy - y) * (yy - y) > r * r) ok = 0;
`endif
                if (ok) begin
                    if (f < 0) f = p;
                    nw++;
                    q_addr.push_back(yy * 640 + xx);
                    q_data.push_back(idx);
                end
                p++;
            end
    endtask

    task automatic drive(input logic clr, input int x, y, r, idx);
        b.iCLEAR  = clr;
        b.iX      = 10'(x);
        b.iY      = 9'(y);
        b.iRADIUS = 4'(r);
        b.iINDEX  = 8'(idx);
    endtask

    task automatic send(input logic clr, input int x, y, r, idx);
        int p, f, nw, n, hs;
        n = 0;
        while (!b.oCMD_READY && n < 2000) begin @(negedge clk); n++; end
        model(clr, x, y, r, idx, p, f, nw);
        wr_cnt = 0; first_wr = -1; done_cyc = -1;
        drive(clr, x, y, r, idx);
        b.iCMD_VALID = 1'b1;
        @(negedge clk);
        hs = hs_last;
        b.iCMD_VALID = 1'b0;
        drive(1'b0, $urandom_range(0, 1023), $urandom_range(0, 511), $urandom_range(0, 15), $urandom_range(0, 255));
        n = 0;
        while (done_cyc < 0 && n < 5000) begin @(posedge clk); n++; end
        chk("done_cyc", done_cyc, hs + 2 + p);
        chk("n_writes", wr_cnt, nw);
        if (nw > 0) chk("first_wr", first_wr, hs + 2 + f);
        chk("sb_empty", q_addr.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int pa, fa, nwa, pb, fb, nwb, n, hc, h1, h2, w0;
        b.iCMD_VALID = 1'b0;
        drive(1'b0, 0, 0, 0, 0);
        bs.iCMD_VALID = 1'b0; bs.iCLEAR = 1'b0; bs.iX = '0; bs.iY = '0; bs.iRADIUS = '0; bs.iINDEX = '0;
        repeat (3) @(negedge clk);
        chk("rst_wren", b.oWREN, 0);
        chk("rst_addr", b.oADDR, 0);
        chk("rst_ready", b.oCMD_READY, 0);
        chk("rst_busy", b.oBUSY, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", b.oCMD_READY, 1);
        chk("busy_after_rst", b.oBUSY, 0);

        send(1'b0, 100, 50, 1, 8'h2A);
        send(1'b0, 0, 0, 2, 8'h11);
        send(1'b0, 639, 479, 1, 8'h33);
        send(1'b0, 639, 10, 3, 8'hC4);
        send(1'b0, 320, 240, 0, 8'h01);
        send(1'b0, 200, 300, 15, 8'hFF);
        send(1'b0, 700, 100, 3, 8'h55);
        send(1'b0, 100, 480, 0, 8'h56);
        for (int i = 0; i < 4; i++)
            send(1'b0, $urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 15), $urandom_range(0, 255));

        // Clear on the small screen: every address 0..767 in order.
        s_next = 0; s_done = 0;
        bs.iCLEAR = 1'b1; bs.iINDEX = 8'h5C; bs.iCMD_VALID = 1'b1;
        @(negedge clk);
        bs.iCMD_VALID = 1'b0; bs.iCLEAR = 1'b0; bs.iINDEX = 8'h00;
        n = 0;
        while (!s_done && n < 3000) begin @(negedge clk); n++; end
        chk("s_count", s_next, 768);

        // Valid held high through a command: second accept only after it finishes.
        model(1'b0, 100, 50, 3, 8'h44, pa, fa, nwa);
        model(1'b0, 200, 100, 0, 8'h77, pb, fb, nwb);
        wr_cnt = 0; hc = hs_cnt;
        drive(1'b0, 100, 50, 3, 8'h44);
        b.iCMD_VALID = 1'b1;
        n = 0;
        while (hs_cnt == hc && n < 100) begin @(negedge clk); n++; end
        h1 = hs_last;
        drive(1'b0, 200, 100, 0, 8'h77);
        n = 0;
        while (hs_cnt == hc + 1 && n < 2000) begin @(negedge clk); n++; end
        h2 = hs_last;
        b.iCMD_VALID = 1'b0;
        done_cyc = -1;
        chk("b2b_gap", h2 - h1, pa + 3);
        n = 0;
        while (done_cyc < 0 && n < 100) begin @(posedge clk); n++; end
        chk("b2b_done", done_cyc, h2 + 2 + pb);
        chk("b2b_writes", wr_cnt, nwa + nwb);
        chk("b2b_sb_empty", q_addr.size(), 0);
        @(negedge clk);

        // Reset in the middle of a large stamp.
        model(1'b0, 300, 200, 15, 8'h99, pa, fa, nwa);
        drive(1'b0, 300, 200, 15, 8'h99);
        b.iCMD_VALID = 1'b1;
        @(negedge clk);
        b.iCMD_VALID = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_rst_wren", b.oWREN, 1);
        #2 rst = 1'b1;
        #1 chk("async_rst_wren", b.oWREN, 0);
        chk("async_rst_busy", b.oBUSY, 0);
        q_addr.delete(); q_data.delete();
        @(negedge clk);
        rst = 1'b0;
        w0 = wr_cnt;
        @(negedge clk);
        chk("post_rst_ready", b.oCMD_READY, 1);
        chk("post_rst_busy", b.oBUSY, 0);
        repeat (5) @(negedge clk);
        chk("post_rst_no_wr", wr_cnt, w0);
        send(1'b0, 5, 470, 2, 8'hEE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
